plot_fifo_clip: RTL and testbench
=================================

# plot_fifo_clip

Downstream pixel stage for the shape drawers (circle, reuleaux). Takes the drawer's one-pixel-per-cycle plot stream, discards off-screen pixels, and converts in-range pixels to linear framebuffer addresses. It buffers them in a small FIFO and drains them to a framebuffer write port that may stall. Clipped pixels and dropped pixels are counted and flagged, so a bench or debug logic can tell whether the drawer ran off-screen or outran the framebuffer.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2
- SCREEN_W, 160, visible width in pixels
- SCREEN_H, 120, visible height in pixels

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_x  in  8  pixel x from drawer (vga_x)
- in_y  in  7  pixel y from drawer (vga_y)
- in_colour  in  3  pixel colour (vga_colour)
- in_plot  in  1  pixel valid this cycle (vga_plot); no backpressure to the drawer
- in_ready  out  1  advisory: FIFO not full
- fb_addr  out  15  framebuffer word address, y*SCREEN_W + x
- fb_data  out  3  colour for fb_addr
- fb_we  out  1  write request; high while the FIFO is non-empty
- fb_ready  in  1  framebuffer accepts the write this cycle
- occupancy  out  $clog2(DEPTH)+1  entries currently held
- clip_count  out  16  saturating count of clipped pixels
- overflow  out  1  sticky: at least one in-range pixel was dropped
- clear_stats  in  1  clears clip_count and overflow

## Operation
- Each cycle with in_plot=1 the pixel is classified in this priority order:
  - clipped: in_x >= SCREEN_W or in_y >= SCREEN_H; not stored; clip_count += 1, saturating at 0xFFFF.
  - pushed: in range and (not full, or a pop happens in the same cycle).
  - dropped: in range, full, and no pop this cycle; not stored; overflow <= 1.
- Address is computed at push time and stored with the colour: addr = (y<<7)+(y<<5)+x. The maximum value, 19199, fits in 15 bits.
- FIFO is show-ahead. fb_addr and fb_data always present the head entry; fb_we = (occupancy != 0).
- Pop occurs when fb_we && fb_ready. The head advances on the next edge.
- Simultaneous push and pop:
  - occupancy unchanged;
  - when full, the push is accepted;
  - when empty, a push and pop cannot coincide, because fb_we=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked with its own counter, so full and empty are unambiguous.
- clear_stats=1: next cycle clip_count=0 and overflow=0. Clear wins over a clip or drop in the same cycle, so that event is not counted.
- fb_addr and fb_data are don't-care while fb_we=0. The implementation holds the last head value, and the bench must not check them then.

## Timing
- Reset, synchronous: on the edge with rst=1 the following apply on the next cycle.
  - occupancy=0, fb_we=0, in_ready=1
  - clip_count=0, overflow=0
  - fb_addr=0, fb_data=0
  - pointers=0
- Reset mid-operation discards all buffered pixels with no write issued. An in_plot in the reset cycle is ignored.
- Latency: a pixel pushed into an empty FIFO at edge N appears with fb_we=1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 pixel/cycle in and out when fb_ready is held at 1. With fb_ready=1 continuously, no drops occur for any in_plot pattern.
- in_ready reflects occupancy after the previous edge. It is not combinationally dependent on fb_ready.
- clip_count and overflow update one edge after the triggering in_plot cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from in_* to any output.

## Test plan
- Reset and basic write:
  - Stimulus: assert rst 2 cycles, then plot (x=10, y=5, colour=3), fb_ready=1.
  - Required: the next cycle shows fb_we=1, fb_addr=810, fb_data=3; the cycle after shows fb_we=0, occupancy=0.
- Clipping:
  - Stimulus: plot (160,0), (0,120), (255,127), then (159,119) colour 7.
  - Required: clip_count=3; a single write with fb_addr=19199, fb_data=7.
- Backpressure, fill and overflow:
  - Stimulus: fb_ready=0, plot 9 in-range pixels x=0..8, y=1.
  - Required: occupancy=8, in_ready=0, overflow=1. Then raise fb_ready: exactly 8 writes in order, addr 160..167, with no gaps.
- Full with simultaneous push and pop:
  - Stimulus: fill to 8, then in one cycle set fb_ready=1 and plot (20,2).
  - Required: occupancy stays 8, overflow stays 0, and (20,2) drains last at addr 340.
- Pointer wrap-around and stats clear:
  - Stimulus: stream 40 pixels with fb_ready toggling 1,0 each cycle, pulse clear_stats together with one clipped plot.
  - Required: write order and addresses match input order across wraps; clip_count=0 and overflow=0 after the clear.
- Reset mid-operation:
  - Stimulus: occupancy=5 with fb_ready=0, assert rst 1 cycle.
  - Required: fb_we=0, occupancy=0, and no buffered pixel is ever written afterwards.

Source files
------------

// File: rtl/plot_fifo_clip.sv
// Pixel clip stage: drops off-screen plots, converts in-range pixels to linear
// framebuffer addresses and buffers them in a show-ahead FIFO for a stallable write port.
module plot_fifo_clip #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  input  logic                     in_plot,
  output logic                     in_ready,
  output logic [14:0]              fb_addr,
  output logic [2:0]               fb_data,
  output logic                     fb_we,
  input  logic                     fb_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              clip_count,
  output logic                     overflow,
  input  logic                     clear_stats
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_C  = OW'(DEPTH);
  localparam logic [OW-1:0] EMPTY_C = {OW{1'b0}};
  localparam logic [8:0]    W_LIM_C = 9'(SCREEN_W);
  localparam logic [7:0]    H_LIM_C = 8'(SCREEN_H);

  logic [14:0]   addr_mem_r [DEPTH];
  logic [2:0]    col_mem_r  [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_next_s;
  logic [OW-1:0] occ_r;
  logic [OW-1:0] occ_next_s;
  logic [14:0]   head_addr_r;
  logic [2:0]    head_data_r;
  logic [14:0]   head_addr_next_s;
  logic [2:0]    head_data_next_s;
  logic [14:0]   pix_addr_s;
  logic [15:0]   clip_count_r;
  logic          overflow_r;
  logic          in_range_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          clip_s;
  logic          drop_s;

  // y*160 + x built from shifts so no multiplier is needed
  function automatic logic [14:0] lin_addr(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] y_w;
    y_w = {8'd0, y};
    return (y_w << 7) + (y_w << 5) + {7'd0, x};
  endfunction

  // Classify the incoming plot against screen bounds and FIFO state
  always_comb begin
    in_range_s = ({1'b0, in_x} < W_LIM_C) && ({1'b0, in_y} < H_LIM_C);
    full_s     = (occ_r == FULL_C);
    pop_s      = (occ_r != EMPTY_C) && fb_ready;
    push_s     = in_plot && in_range_s && (!full_s || pop_s);
    clip_s     = in_plot && !in_range_s;
    drop_s     = in_plot && in_range_s && full_s && !pop_s;
    pix_addr_s = lin_addr(in_x, in_y);
  end

  // Next occupancy, read pointer and head entry
  always_comb begin
    occ_next_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OW'(1);
      2'b01:   occ_next_s = occ_r - OW'(1);
      default: occ_next_s = occ_r;
    endcase
    rd_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    // The new head is the pixel being written now if it lands in the next read slot
    if (occ_next_s == EMPTY_C) begin
      head_addr_next_s = head_addr_r;
      head_data_next_s = head_data_r;
    end else if (push_s && (rd_next_s == wr_ptr_r)) begin
      head_addr_next_s = pix_addr_s;
      head_data_next_s = in_colour;
    end else begin
      head_addr_next_s = addr_mem_r[rd_next_s];
      head_data_next_s = col_mem_r[rd_next_s];
    end
  end

  // Storage array, left unreset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      addr_mem_r[wr_ptr_r] <= pix_addr_s;
      col_mem_r[wr_ptr_r]  <= in_colour;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      occ_r       <= EMPTY_C;
      head_addr_r <= 15'd0;
      head_data_r <= 3'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r    <= rd_next_s;
      occ_r       <= occ_next_s;
      head_addr_r <= head_addr_next_s;
      head_data_r <= head_data_next_s;
    end
  end

  // Clip counter and sticky overflow; clear beats a same-cycle event
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      clip_count_r <= 16'd0;
      overflow_r   <= 1'b0;
    end else begin
      if (clip_s && (clip_count_r != 16'hFFFF)) begin
        clip_count_r <= clip_count_r + 16'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign in_ready   = (occ_r != FULL_C);
  assign fb_we      = (occ_r != EMPTY_C);
  assign fb_addr    = head_addr_r;
  assign fb_data    = head_data_r;
  assign occupancy  = occ_r;
  assign clip_count = clip_count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_plot_fifo_clip.sv
// Directed bench for plot_fifo_clip: a vector table for reset/write/clip,
// then sequences for fill/overflow, full push+pop, wrap with stats clear, and mid-run reset.
module tb_plot_fifo_clip;

  logic        clk = 1'b0;
  logic        rst, in_plot, in_ready, fb_we, fb_ready, overflow, clear_stats;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour, fb_data;
  logic [14:0] fb_addr;
  logic [3:0]  occupancy;
  logic [15:0] clip_count;

  int checks = 0;
  int errors = 0;

  plot_fifo_clip #(.DEPTH(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst(rst), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_ready(in_ready), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_we(fb_we), .fb_ready(fb_ready), .occupancy(occupancy),
    .clip_count(clip_count), .overflow(overflow), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  col;
    logic        rdy;
    logic        clr;
    logic        e_we;
    logic [14:0] e_addr;
    logic [2:0]  e_data;
    logic [3:0]  e_occ;
    logic        e_ready;
    logic [15:0] e_clip;
    logic        e_ovf;
    logic        chk_addr;
  } vec_t;

  typedef struct {
    logic [14:0] a;
    logic [2:0]  c;
  } ent_t;

  vec_t vecs [11];
  ent_t q [$];
  int   m_clip;
  logic m_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input logic r);
    in_plot = p; in_x = x; in_y = y; in_colour = c; fb_ready = r;
  endtask

  initial begin
    rst = 1'b1; clear_stats = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);

    // rst plot x y col rdy clr | we addr data occ ready clip ovf chk_addr
    vecs[0]  = '{1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'd10,  7'd5,   3'd3, 1'b1, 1'b0, 1'b1, 15'd810,   3'd3, 4'd1, 1'b1, 16'd0, 1'b0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'd160, 7'd0,   3'd1, 1'b1, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'd0,   7'd120, 3'd1, 1'b1, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd2, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'd255, 7'd127, 3'd1, 1'b1, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'd159, 7'd119, 3'd7, 1'b1, 1'b0, 1'b1, 15'd19199, 3'd7, 4'd1, 1'b1, 16'd3, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b1, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'd1,   7'd1,   3'd1, 1'b1, 1'b0, 1'b0, 15'd0,     3'd0, 4'd0, 1'b1, 16'd0, 1'b0, 1'b1};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; clear_stats = vecs[i].clr;
      drive(vecs[i].plot, vecs[i].x, vecs[i].y, vecs[i].col, vecs[i].rdy);
      tick();
      chk($sformatf("v%0d_we", i), 32'(fb_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_clip", i), 32'(clip_count), 32'(vecs[i].e_clip));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
      if (vecs[i].chk_addr) begin
        chk($sformatf("v%0d_addr", i), 32'(fb_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d_data", i), 32'(fb_data), 32'(vecs[i].e_data));
      end
    end
    rst = 1'b0; clear_stats = 1'b0;

    // Fill with the write port stalled; the ninth pixel is dropped
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 8'(i), 7'd1, 3'(i), 1'b0);
      tick();
      if (i < 8) chk($sformatf("fill%0d_occ", i), 32'(occupancy), 32'(i + 1));
    end
    chk("fill_occ", 32'(occupancy), 32'd8);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_head", 32'(fb_addr), 32'd160);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
      chk($sformatf("drain%0d_we", k), 32'(fb_we), 32'd1);
      chk($sformatf("drain%0d_addr", k), 32'(fb_addr), 32'(160 + k));
      chk($sformatf("drain%0d_data", k), 32'(fb_data), 32'(k));
      tick();
    end
    chk("drain_we", 32'(fb_we), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(i), 7'd2, 3'd1, 1'b0);
      tick();
    end
    chk("full_occ", 32'(occupancy), 32'd8);
    drive(1'b1, 8'd20, 7'd2, 3'd5, 1'b1);
    tick();
    chk("pp_occ", 32'(occupancy), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
      chk($sformatf("pp%0d_we", k), 32'(fb_we), 32'd1);
      chk($sformatf("pp%0d_addr", k), 32'(fb_addr), (k < 7) ? 32'(321 + k) : 32'd340);
      if (k == 7) chk("pp_last_data", 32'(fb_data), 32'd5);
      tick();
    end
    chk("pp_end_we", 32'(fb_we), 32'd0);

    // Stream across pointer wraps with fb_ready toggling, checked against a queue
    m_clip = 0; m_drop = 1'b0;
    for (int cyc = 0; cyc < 72; cyc++) begin
      logic       p, rdy, inr, mpop;
      logic [7:0] x;
      logic [6:0] y;
      int         sz;
      p   = (cyc < 40);
      rdy = (cyc % 2 == 0);
      x   = (cyc == 10) ? 8'd200 : 8'((cyc * 3) % 160);
      y   = 7'((cyc * 7) % 120);
      drive(p, x, y, 3'(cyc), rdy);
      sz = q.size();
      chk($sformatf("wr%0d_we", cyc), 32'(fb_we), 32'(sz != 0));
      if (sz != 0) begin
        chk($sformatf("wr%0d_addr", cyc), 32'(fb_addr), 32'(q[0].a));
        chk($sformatf("wr%0d_data", cyc), 32'(fb_data), 32'(q[0].c));
      end
      inr  = (x < 8'd160) && (y < 7'd120);
      mpop = (sz != 0) && rdy;
      if (mpop) void'(q.pop_front());
      if (p && inr && (sz < 8 || mpop)) q.push_back('{15'(int'(y) * 160 + int'(x)), 3'(cyc)});
      else if (p && inr) m_drop = 1'b1;
      if (p && !inr) m_clip++;
      tick();
    end
    chk("wrap_empty", 32'(occupancy), 32'(q.size()));
    chk("wrap_clip", 32'(clip_count), 32'(m_clip));
    chk("wrap_ovf", 32'(overflow), 32'(m_drop));
    clear_stats = 1'b1;
    drive(1'b1, 8'd200, 7'd3, 3'd0, 1'b1);
    tick();
    clear_stats = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
    chk("clr_clip", 32'(clip_count), 32'd0);
    chk("clr_ovf2", 32'(overflow), 32'd0);
    tick();
    chk("clr_clip_hold", 32'(clip_count), 32'd0);

    // Reset while holding five stalled pixels
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(30 + i), 7'd4, 3'd2, 1'b0);
      tick();
    end
    chk("pre_rst_occ", 32'(occupancy), 32'd5);
    rst = 1'b1;
    drive(1'b1, 8'd3, 7'd3, 3'd2, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0, 1'b1);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_addr", 32'(fb_addr), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("post_rst%0d_we", k), 32'(fb_we), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
